ps2_key_event_queue: RTL and testbench
======================================

// Module: ps2_key_event_queue
// PURPOSE
//  Successor to the single-register keyboard decoder. Consumes raw PS/2 bytes (data/ready/nextdata_n) from ps2_keyboard.
//  Decodes make/break/E0-extended sequences, tracks modifiers and queues complete key events in a parametrised FIFO.
//  The VGA text display drains the queue at its own pace, so no keystroke is lost while a line is redrawn.
// PARAMETERS
//  FIFO_DEPTH  8  event entries; power of 2, >=2
//  COUNT_W     8  width of press counter
// PORTS
//  clk          in   1          system clock (CLOCK_50)
//  reset        in   1          synchronous, active-high
//  ready        in   1          ps2_keyboard: byte available
//  data         in   8          ps2_keyboard: byte value
//  nextdata_n   out  1          low for one cycle = byte consumed
//  rd_en        in   1          pop head event (ignored when empty)
//  ev_valid     out  1          queue non-empty; head fields valid
//  ev_code      out  8          head scancode (without E0/F0)
//  ev_ext       out  1          head was E0-prefixed
//  ev_break     out  1          head is a release
//  ev_mods      out  4          {caps_lock,alt,ctrl,shift} after applying head's byte
//  fifo_level   out  clog2(FIFO_DEPTH)+1  entries held
//  overflow     out  1          sticky: event dropped on full
//  press_count  out  COUNT_W    make events queued, wraps 2^COUNT_W-1 -> 0
// BEHAVIOUR
//  Reset: nextdata_n=1, ev_valid=0, fifo_level=0, overflow=0, press_count=0, mods=0, decoder state S_IDLE, held-key cleared.
//   Reset mid-sequence (after E0/F0) discards the partial sequence.
//  Handshake: byte is accepted in cycle N when ready=1 and nextdata_n=1. nextdata_n=0 in N+1 only, then 1 again.
//   No byte is accepted while nextdata_n=0.
//  Decoder FSM (advances only on an accepted byte):
//   S_IDLE:  E0->S_EXT; F0->S_BRK; other->emit make(ext=0), stay
//   S_EXT:   F0->S_EXTBRK; E0->stay; other->emit make(ext=1), ->S_IDLE
//   S_BRK:   any->emit break(ext=0), ->S_IDLE
//   S_EXTBRK:any->emit break(ext=1), ->S_IDLE
//   Emitting a code also sets the FSM to S_IDLE. Bytes AA/FA/EE/FE/00/FF in S_IDLE are dropped without an event.
//  Modifiers, applied before the event is pushed:
//   shift = L(12) or R(59) held; ctrl = 14 or E0 14; alt = 11 or E0 11.
//   caps_lock toggles on the first make of 58 only. Repeated 58 makes while held do not toggle.
//  Held key: one register {ext,code} = last make; cleared by a matching break.
//   A make equal to the held key is a typematic repeat.
//  Emit latency: final byte accepted in N -> ev_valid=1 (if queue was empty) in N+2.
//  FIFO: first-word-fall-through; head fields are combinational from the read pointer.
//   rd_en && ev_valid pops at the clock edge.
//   Full + push without pop: event dropped, overflow<=1 until reset. FIFO contents are unchanged.
//   Full + push + pop in the same cycle: both occur, level unchanged, overflow untouched.
//   Empty + rd_en: no effect; pointers and level unchanged.
//   Pointers wrap modulo FIFO_DEPTH.
//  press_count increments by 1 per queued make event. A dropped (overflow) event does not count.
// CONFIGURATION
//  KEY_REPEAT_FILTER_EN defined: typematic repeat makes are neither queued nor counted. Only the first make per hold
//   produces an event. Modifier state is still updated.
//  Not defined: every make, including repeats, is queued and counted. Caps toggling is unaffected in both builds.
// TESTING
//  1. Bytes 1C,F0,1C -> 2 events {1C,ext0,brk0},{1C,ext0,brk1}; press_count=1; nextdata_n low 1 cycle per byte.
//  2. E0,75,E0,F0,75 -> {75,ext1,brk0},{75,ext1,brk1}; 12 then 1C -> second event ev_mods=4'b0001.
//  3. 58,F0,58,58 -> caps_lock=1 after the first make, still 1 after the break, 0 after the second make.
//     Then 58,58 held: caps toggles once only.
//  4. 1C x5 (no break): filter build -> 1 event, press_count=1; unfiltered build -> 5 events, press_count=5.
//  5. FIFO_DEPTH=4, no rd_en, 5 makes -> fifo_level=4, overflow=1, head still the first code.
//     Push+pop on full -> level stays 4.
//  6. Reset asserted after E0 accepted, then 1C -> event ext=0. Reset clears press_count, level, overflow.

Source files
------------

// File: rtl/ps2_key_event_queue.sv
// PS/2 scancode decoder with modifier tracking, feeding a first-word-fall-through key event queue.
// Optional build macro: KEY_REPEAT_FILTER_EN drops typematic repeat makes before they reach the queue.
module ps2_key_event_queue #(
  parameter int FIFO_DEPTH = 8,
  parameter int COUNT_W    = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ready,
  input  logic [7:0]                  data,
  output logic                        nextdata_n,
  input  logic                        rd_en,
  output logic                        ev_valid,
  output logic [7:0]                  ev_code,
  output logic                        ev_ext,
  output logic                        ev_break,
  output logic [3:0]                  ev_mods,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic [COUNT_W-1:0]          press_count
);

  // state    | meaning
  // S_IDLE   | waiting for a prefix or a plain make code
  // S_EXT    | E0 seen, expecting an extended make or F0
  // S_BRK    | F0 seen, next byte is a release
  // S_EXTBRK | E0 F0 seen, next byte is an extended release

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK} state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [3:0] mods;
  } event_t;

  state_t       state, state_nx;
  logic         accept;
  logic         byte_vld;
  logic [7:0]   byte_q;
  logic         emit, dec_ext, dec_brk, is_ignored;
  logic [8:0]   key_id;

  logic         lshift, rshift, lctrl, rctrl, lalt, ralt, caps_lock, caps_held;
  logic         lshift_nx, rshift_nx, lctrl_nx, rctrl_nx, lalt_nx, ralt_nx, caps_nx, caps_held_nx;
  logic         held_vld, held_vld_nx;
  logic [8:0]   held_key, held_key_nx;
  logic         is_repeat, push_req;
  event_t       new_ev;

  event_t       mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic         full, empty, do_pop, do_wr, do_drop;

  assign accept = ready & nextdata_n;

  // One-deep byte stage: the byte accepted in N is decoded and pushed at the end of N+1.
  always_ff @(posedge clk) begin
    if (reset) begin
      nextdata_n <= 1'b1;
      byte_vld   <= 1'b0;
      byte_q     <= 8'h00;
    end else begin
      nextdata_n <= ~accept;
      byte_vld   <= accept;
      if (accept) byte_q <= data;
    end
  end

  assign is_ignored = byte_q inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

  always_comb begin
    state_nx = state;
    emit     = 1'b0;
    dec_ext  = 1'b0;
    dec_brk  = 1'b0;
    if (byte_vld) begin
      case (state)
        S_IDLE: begin
          if (byte_q == 8'hE0)      state_nx = S_EXT;
          else if (byte_q == 8'hF0) state_nx = S_BRK;
          else if (!is_ignored)     emit = 1'b1;
        end
        S_EXT: begin
          if (byte_q == 8'hF0) state_nx = S_EXTBRK;
          else if (byte_q != 8'hE0) begin
            emit     = 1'b1;
            dec_ext  = 1'b1;
            state_nx = S_IDLE;
          end
        end
        S_BRK: begin
          emit     = 1'b1;
          dec_brk  = 1'b1;
          state_nx = S_IDLE;
        end
        default: begin
          emit     = 1'b1;
          dec_ext  = 1'b1;
          dec_brk  = 1'b1;
          state_nx = S_IDLE;
        end
      endcase
    end
  end

  assign key_id = {dec_ext, byte_q};

  always_comb begin
    lshift_nx    = lshift;
    rshift_nx    = rshift;
    lctrl_nx     = lctrl;
    rctrl_nx     = rctrl;
    lalt_nx      = lalt;
    ralt_nx      = ralt;
    caps_nx      = caps_lock;
    caps_held_nx = caps_held;
    held_vld_nx  = held_vld;
    held_key_nx  = held_key;
    if (emit) begin
      case (key_id)
        9'h012: lshift_nx = ~dec_brk;
        9'h059: rshift_nx = ~dec_brk;
        9'h014: lctrl_nx  = ~dec_brk;
        9'h114: rctrl_nx  = ~dec_brk;
        9'h011: lalt_nx   = ~dec_brk;
        9'h111: ralt_nx   = ~dec_brk;
        9'h058: begin
          // Caps only toggles on the press edge, not on typematic repeats.
          if (!dec_brk && !caps_held) caps_nx = ~caps_lock;
          caps_held_nx = ~dec_brk;
        end
        default: ;
      endcase
      if (!dec_brk) begin
        held_vld_nx = 1'b1;
        held_key_nx = key_id;
      end else if (held_vld && (held_key == key_id)) begin
        held_vld_nx = 1'b0;
      end
    end
  end

  assign is_repeat = emit && !dec_brk && held_vld && (held_key == key_id);

`ifdef KEY_REPEAT_FILTER_EN
  assign push_req = emit && !is_repeat;
`else
  assign push_req = emit;
`endif

  assign new_ev.code = byte_q;
  assign new_ev.ext  = dec_ext;
  assign new_ev.brk  = dec_brk;
  assign new_ev.mods = {caps_nx, lalt_nx | ralt_nx, lctrl_nx | rctrl_nx, lshift_nx | rshift_nx};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      lctrl     <= 1'b0;
      rctrl     <= 1'b0;
      lalt      <= 1'b0;
      ralt      <= 1'b0;
      caps_lock <= 1'b0;
      caps_held <= 1'b0;
      held_vld  <= 1'b0;
      held_key  <= 9'h000;
    end else begin
      state     <= state_nx;
      lshift    <= lshift_nx;
      rshift    <= rshift_nx;
      lctrl     <= lctrl_nx;
      rctrl     <= rctrl_nx;
      lalt      <= lalt_nx;
      ralt      <= ralt_nx;
      caps_lock <= caps_nx;
      caps_held <= caps_held_nx;
      held_vld  <= held_vld_nx;
      held_key  <= held_key_nx;
    end
  end

  assign full    = (fifo_level == LW'(FIFO_DEPTH));
  assign empty   = (fifo_level == '0);
  assign do_pop  = rd_en && !empty;
  assign do_wr   = push_req && (!full || do_pop);
  assign do_drop = push_req && full && !do_pop;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= new_ev;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      overflow    <= 1'b0;
      press_count <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: ;
      endcase
      if (do_drop) overflow <= 1'b1;
      if (do_wr && !new_ev.brk) press_count <= press_count + COUNT_W'(1);
    end
  end

  assign ev_valid = !empty;
  assign ev_code  = mem[rd_ptr].code;
  assign ev_ext   = mem[rd_ptr].ext;
  assign ev_break = mem[rd_ptr].brk;
  assign ev_mods  = mem[rd_ptr].mods;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Self-checking bench for ps2_key_event_queue: directed scenarios with literal expectations,
// then random byte/pop/reset traffic checked every cycle against a sequence-level model.
module tb_ps2_key_event_queue;
  localparam int DEPTH = 4;
  localparam int CW    = 8;
`ifdef KEY_REPEAT_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    reset = 1'b1;
  logic                    ready = 1'b0;
  logic [7:0]              data = 8'h00;
  logic                    rd_en = 1'b0;
  logic                    nextdata_n, ev_valid, ev_ext, ev_break, overflow;
  logic [7:0]              ev_code;
  logic [3:0]              ev_mods;
  logic [$clog2(DEPTH):0]  fifo_level;
  logic [CW-1:0]           press_count;

  ps2_key_event_queue #(.FIFO_DEPTH(DEPTH), .COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .ready(ready), .data(data), .nextdata_n(nextdata_n),
    .rd_en(rd_en), .ev_valid(ev_valid), .ev_code(ev_code), .ev_ext(ev_ext),
    .ev_break(ev_break), .ev_mods(ev_mods), .fifo_level(fifo_level),
    .overflow(overflow), .press_count(press_count)
  );

  typedef struct {
    logic [7:0] code;
    bit         ext;
    bit         brk;
    logic [3:0] mods;
  } ev_t;

  // Model state: expected queue contents plus the key/prefix knowledge needed to build events.
  ev_t       q[$];
  bit        pressed [512];
  bit        caps, hv, e0, f0, m_nd, pend, ovf;
  logic [8:0] hk;
  logic [7:0] pb;
  logic [CW-1:0] pcnt;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ignored(input logic [7:0] b);
    return b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  endfunction

  task automatic model_reset();
    q.delete();
    foreach (pressed[i]) pressed[i] = 1'b0;
    caps = 0; hv = 0; hk = '0; e0 = 0; f0 = 0; m_nd = 1; pend = 0; pb = '0; ovf = 0; pcnt = '0;
  endtask

  task automatic model_step();
    int sz;
    bit do_pop, have, rep, acc;
    ev_t e;
    logic [8:0] k;
    if (reset) begin
      model_reset();
      return;
    end
    sz = q.size();
    do_pop = rd_en && (sz > 0);
    have = 0;
    if (pend && !(!e0 && !f0 && ignored(pb))) begin
      if (!f0 && pb == 8'hE0) e0 = 1;
      else if (!f0 && pb == 8'hF0) f0 = 1;
      else begin
        e.code = pb; e.ext = e0; e.brk = f0;
        e0 = 0; f0 = 0;
        k = {e.ext, pb};
        rep = 0;
        if (e.brk) begin
          pressed[k] = 0;
          if (hv && hk == k) hv = 0;
        end else begin
          rep = hv && (hk == k);
          if (k == 9'h058 && !pressed[k]) caps = !caps;
          pressed[k] = 1;
          hv = 1; hk = k;
        end
        e.mods = {caps, pressed[9'h011] | pressed[9'h111], pressed[9'h014] | pressed[9'h114],
                  pressed[9'h012] | pressed[9'h059]};
        have = !(FILTER && rep);
      end
    end
    if (do_pop) void'(q.pop_front());
    if (have) begin
      if (sz == DEPTH && !do_pop) ovf = 1;
      else begin
        q.push_back(e);
        if (!e.brk) pcnt = pcnt + 1'b1;
      end
    end
    acc = ready && m_nd;
    pend = acc;
    if (acc) pb = data;
    m_nd = !acc;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("nextdata_n", nextdata_n, m_nd);
        chk("ev_valid", ev_valid, q.size() != 0);
        chk("fifo_level", fifo_level, q.size());
        chk("overflow", overflow, ovf);
        chk("press_count", press_count, pcnt);
        if (q.size() != 0) begin
          chk("ev_code", ev_code, q[0].code);
          chk("ev_ext", ev_ext, q[0].ext);
          chk("ev_break", ev_break, q[0].brk);
          chk("ev_mods", ev_mods, q[0].mods);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    while (!nextdata_n && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("handshake_wait", guard < 10, 1);
    ready = 1'b1;
    data  = b;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [7:0] pool [14] = '{8'h12, 8'h59, 8'h14, 8'h11, 8'h58, 8'h1C, 8'h75,
                            8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hAA, 8'h00, 8'hFF};

  initial begin
    idle(2);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_nextdata_n", nextdata_n, 1);
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_press", press_count, 0);

    // make / break of a plain key
    send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C); idle(3);
    chk("t1_level", fifo_level, 2);
    chk("t1_code", ev_code, 8'h1C);
    chk("t1_brk0", ev_break, 0);
    chk("t1_press", press_count, 1);
    pop();
    chk("t1_brk1", ev_break, 1);
    chk("t1_ext", ev_ext, 0);
    pop();

    // extended make/break, then shift-modified key
    send_byte(8'hE0); send_byte(8'h75); send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    send_byte(8'h12); send_byte(8'h1C); idle(3);
    chk("t2_level", fifo_level, 4);
    chk("t2_code", ev_code, 8'h75);
    chk("t2_ext", ev_ext, 1);
    pop();
    chk("t2_brk", ev_break, 1);
    pop(); pop();
    chk("t2_code_1c", ev_code, 8'h1C);
    chk("t2_mods", ev_mods, 4'b0001);
    pop();
    send_byte(8'hF0); send_byte(8'h12); idle(3);
    chk("t2_mods_rel", ev_mods, 4'b0000);
    pop();

    // caps lock toggling
    reset_dut();
    send_byte(8'h58); idle(3);
    chk("t3_caps_on", ev_mods, 4'b1000);
    pop();
    send_byte(8'hF0); send_byte(8'h58); idle(3);
    chk("t3_caps_brk", ev_mods, 4'b1000);
    pop();
    send_byte(8'h58); idle(3);
    chk("t3_caps_off", ev_mods, 4'b0000);
    pop();
    send_byte(8'h58); idle(3);
    chk("t3_repeat_level", fifo_level, FILTER ? 0 : 1);
    pop();
    send_byte(8'hF0); send_byte(8'h58); idle(3);
    pop();
    send_byte(8'h58); send_byte(8'h58); idle(3);
    chk("t3_held_level", fifo_level, FILTER ? 1 : 2);
    chk("t3_held_caps", ev_mods, 4'b1000);
    pop(); pop(); idle(2);

    // typematic repeats
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      send_byte(8'h1C); idle(3); pop();
    end
    chk("t4_press", press_count, FILTER ? 1 : 5);

    // full queue, push+pop on full, overflow
    reset_dut();
    send_byte(8'h15); send_byte(8'h1D); send_byte(8'h24); send_byte(8'h2D); idle(3);
    chk("t5_full", fifo_level, 4);
    chk("t5_ovf0", overflow, 0);
    send_byte(8'h2C);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    idle(2);
    chk("t5_pushpop_level", fifo_level, 4);
    chk("t5_pushpop_ovf", overflow, 0);
    chk("t5_pushpop_head", ev_code, 8'h1D);
    send_byte(8'h33); idle(3);
    chk("t5_ovf1", overflow, 1);
    chk("t5_level", fifo_level, 4);
    chk("t5_head", ev_code, 8'h1D);
    chk("t5_press", press_count, 5);

    // reset discards a partial E0 sequence
    reset_dut();
    chk("t6_ovf_clr", overflow, 0);
    send_byte(8'hE0); idle(2);
    reset_dut();
    send_byte(8'h1C); idle(3);
    chk("t6_ext", ev_ext, 0);
    chk("t6_code", ev_code, 8'h1C);
    chk("t6_level", fifo_level, 1);
    chk("t6_press", press_count, 1);
    reset_dut();

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) != 0)
        data = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 13)];
      rd_en = ((i / 500) % 2 == 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    ready = 1'b0; rd_en = 1'b0; reset = 1'b0;
    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
